// File: rtl/uart_pkg.sv
// Shared UART types: frame-format encodings, TX FSM states and format helpers.
// The configurable transmitter uses this package, and the receiver will reuse it.
package uart_pkg;

  localparam int CLK_FREQ     = 100_000_000;
  localparam int DEFAULT_BAUD = 19200;
  localparam int DEFAULT_DIV  = CLK_FREQ / DEFAULT_BAUD - 1;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [1:0] {
    DATA_BITS_5 = 2'b00,
    DATA_BITS_6 = 2'b01,
    DATA_BITS_7 = 2'b10,
    DATA_BITS_8 = 2'b11
  } data_bits_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic logic [3:0] data_bits_n(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  // Code 11 is a second spelling of "no parity".
  function automatic parity_e parity_decode(input logic [1:0] code);
    case (code)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle tick every max(div,1)+1 clocks, restartable synchronously.
// Latency: the first tick comes max(div,1)+1 cycles after restart drops; it has no backpressure.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;

  // A divisor of zero would give a one-clock bit, so it is clamped to two clocks.
  assign div_eff = (div == '0) ? DIV_W'(1) : div;
  assign tick    = !restart && (cnt == div_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == div_eff)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART TX: pops a FWFT FIFO word and sends it as 5-8 data bits, optional parity, 1-2 stops.
// Line falls two edges after fifo_empty is seen low; the FIFO is read only when the serialiser is free.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [7:0]       dout,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic             read_enable,
  output logic             tx_pin,
  output logic             transmission_complete
);

  tx_state_e        state;
  logic [7:0]       shift;
  logic [2:0]       last_bit;
  logic [2:0]       bit_cnt;
  parity_e          par_mode;
  logic             stop2_q;
  logic [DIV_W-1:0] div_q;
  logic             par_acc;
  logic             tick;
  logic             baud_restart;

  // The bit timer is held at zero until the first start bit begins.
  assign baud_restart = (state == ST_IDLE) || (state == ST_LOAD);

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(baud_restart),
    .div    (div_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      tx_pin                <= 1'b1;
      read_enable           <= 1'b0;
      transmission_complete <= 1'b1;
      shift                 <= '0;
      last_bit              <= '0;
      bit_cnt               <= '0;
      par_mode              <= PAR_NONE;
      stop2_q               <= 1'b0;
      div_q                 <= '0;
      par_acc               <= 1'b0;
    end else begin
      read_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_pin                <= 1'b1;
          transmission_complete <= 1'b1;
          if (!fifo_empty) begin
            state       <= ST_LOAD;
            read_enable <= 1'b1;
          end
        end

        // dout is the FIFO head while read_enable is high, so it is captured on the popping edge.
        ST_LOAD: begin
          shift                 <= dout;
          last_bit              <= 3'(data_bits_n(cfg_data_bits) - 4'd1);
          par_mode              <= parity_decode(cfg_parity);
          stop2_q               <= cfg_stop2;
          div_q                 <= cfg_div;
          bit_cnt               <= '0;
          par_acc               <= 1'b0;
          transmission_complete <= 1'b0;
          tx_pin                <= 1'b0;
          state                 <= ST_START;
        end

        ST_START: begin
          if (tick) begin
            tx_pin  <= shift[0];
            par_acc <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == last_bit) begin
              bit_cnt <= '0;
              if (par_mode == PAR_NONE) begin
                tx_pin <= 1'b1;
                state  <= ST_STOP;
              end else begin
                tx_pin <= par_acc ^ (par_mode == PAR_ODD);
                state  <= ST_PARITY;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_pin  <= shift[0];
              par_acc <= par_acc ^ shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            tx_pin  <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_STOP;
          end
        end

        // bit_cnt doubles as the stop-bit index; back-to-back frames skip IDLE entirely.
        ST_STOP: begin
          if (tick) begin
            if (stop2_q && (bit_cnt == 3'd0)) begin
              bit_cnt <= 3'd1;
            end else if (!fifo_empty) begin
              tx_pin      <= 1'b1;
              read_enable <= 1'b1;
              state       <= ST_LOAD;
            end else begin
              tx_pin                <= 1'b1;
              transmission_complete <= 1'b1;
              state                 <= ST_IDLE;
            end
          end
        end

        default: begin
          tx_pin                <= 1'b1;
          transmission_complete <= 1'b1;
          state                 <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: FWFT FIFO model, per-bit line checks, pulse and busy-time counters.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  dout = 8'h00;
  logic [15:0] cfg_div = 16'd9;
  logic [1:0]  cfg_data_bits = 2'b11;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        read_enable;
  logic        tx_pin;
  logic        transmission_complete;

  int checks = 0;
  int failures = 0;
  int re_cnt = 0;
  int viol = 0;
  int tc_low = 0;
  int re0;
  int tc0;
  logic pend = 1'b0;
  logic [7:0] q[$];

  uart_tx_cfg #(.DIV_W(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .fifo_empty           (fifo_empty),
    .dout                 (dout),
    .cfg_div              (cfg_div),
    .cfg_data_bits        (cfg_data_bits),
    .cfg_parity           (cfg_parity),
    .cfg_stop2            (cfg_stop2),
    .read_enable          (read_enable),
    .tx_pin               (tx_pin),
    .transmission_complete(transmission_complete)
  );

  always #5 clk = ~clk;

  // Observation at the falling edge: pops, illegal pops, busy cycles.
  initial forever begin
    @(negedge clk);
    if (read_enable) re_cnt++;
    if (read_enable && fifo_empty) viol++;
    if (!transmission_complete) tc_low++;
    pend = read_enable;
  end

  // First-word-fall-through FIFO: head is popped on the edge that ends the read_enable cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (pend && q.size() > 0) void'(q.pop_front());
    fifo_empty = (q.size() == 0);
    dout = (q.size() > 0) ? q[0] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bits[i] is the i-th symbol on the line: start, data LSB first, parity, stops.
  task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits, input int p);
    logic seen;
    int bad;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = read_enable;
    end
    chk({tag, "_load_seen"}, 32'(seen), 32'd1);
    chk({tag, "_load_line_high"}, 32'(tx_pin), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        if (tx_pin !== bits[b]) bad++;
      end
      chk($sformatf("%s_bit%0d_bad_cycles", tag, b), 32'(bad), 32'd0);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 600 && !idle; i++) begin
      @(negedge clk);
      idle = transmission_complete;
    end
    chk({tag, "_idle_reached"}, 32'(idle), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx_pin", 32'(tx_pin), 32'd1);
    chk("reset_read_enable", 32'(read_enable), 32'd0);
    chk("reset_tc", 32'(transmission_complete), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_read", 32'(re_cnt), 32'd0);

    // 8N1, P=10, 0x55
    cfg_div = 16'd9; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    re0 = re_cnt; tc0 = tc_low;
    q.push_back(8'h55);
    check_frame("8n1", 12'b00_1_01010101_0, 10, 10);
    wait_idle("8n1");
    chk("8n1_reads", 32'(re_cnt - re0), 32'd1);
    chk("8n1_busy_cycles", 32'(tc_low - tc0), 32'd100);

    // 7E1, 0x41: seven data bits 1,0,0,0,0,0,1, even parity 0
    cfg_data_bits = 2'b10; cfg_parity = 2'b01;
    re0 = re_cnt; tc0 = tc_low;
    q.push_back(8'h41);
    check_frame("7e1", 12'b00_1_0_1000001_0, 10, 10);
    wait_idle("7e1");
    chk("7e1_busy_cycles", 32'(tc_low - tc0), 32'd100);

    // 8O2, 0x00: odd parity 1, two stop bits
    cfg_data_bits = 2'b11; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    tc0 = tc_low;
    q.push_back(8'h00);
    check_frame("8o2", 12'b11_1_00000000_0, 12, 10);
    wait_idle("8o2");
    chk("8o2_busy_cycles", 32'(tc_low - tc0), 32'd120);

    // 5N1, 0xFF, divisor 0 clamps to P=2
    cfg_data_bits = 2'b00; cfg_parity = 2'b11; cfg_stop2 = 1'b0; cfg_div = 16'd0;
    tc0 = tc_low;
    q.push_back(8'hFF);
    check_frame("5n1", 12'b00000_1_11111_0, 7, 2);
    wait_idle("5n1");
    chk("5n1_busy_cycles", 32'(tc_low - tc0), 32'd14);

    // Back-to-back, divisor changed mid-frame-1
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_div = 16'd9;
    re0 = re_cnt; tc0 = tc_low;
    q.push_back(8'hA5); q.push_back(8'h3C); q.push_back(8'h81);
    fork
      check_frame("b2b_f1", 12'b00_1_10100101_0, 10, 10);
      begin
        repeat (20) @(negedge clk);
        cfg_div = 16'd4;
      end
    join
    check_frame("b2b_f2", 12'b00_1_00111100_0, 10, 5);
    check_frame("b2b_f3", 12'b00_1_10000001_0, 10, 5);
    wait_idle("b2b");
    chk("b2b_reads", 32'(re_cnt - re0), 32'd3);
    chk("b2b_busy_cycles", 32'(tc_low - tc0), 32'd202);

    // Reset during data bit 3 of 0xF0 (line low there)
    cfg_div = 16'd9;
    q.push_back(8'hF0);
    for (int i = 0; i < 400 && !read_enable; i++) @(negedge clk);
    repeat (45) @(negedge clk);
    chk("rst_pre_line_low", 32'(tx_pin), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx_pin", 32'(tx_pin), 32'd1);
    chk("rst_async_tc", 32'(transmission_complete), 32'd1);
    chk("rst_async_read_enable", 32'(read_enable), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    re0 = re_cnt;
    repeat (50) @(negedge clk);
    chk("rst_after_no_read", 32'(re_cnt - re0), 32'd0);
    chk("rst_after_tx_pin", 32'(tx_pin), 32'd1);
    chk("rst_after_tc", 32'(transmission_complete), 32'd1);
    chk("read_while_empty", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
